// File: rtl/fp_line_quantizer.sv
// Serial FP32 line quantizer: converts each lane of a packed FP32 line to a signed
// fixed-point integer scaled by 2^StepSizeExp. Optional macro: QUANT_ROUND_NEAREST_EN.
module fp_line_quantizer #(
  parameter int L2WIDTH   = 512,
  parameter int WWIDTH    = 32,
  parameter int EXPLENGTH = 8,
  parameter int QWIDTH    = 16,
  parameter int LANES     = L2WIDTH / WWIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [L2WIDTH-1:0]          in_line,
  input  logic [EXPLENGTH-1:0]        StepSizeExp,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*QWIDTH-1:0]     out_line,
  output logic                        out_sat
);

  localparam int CW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SHW = ((EXPLENGTH > 8) ? EXPLENGTH : 8) + 2;
  localparam int MW  = 25;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  localparam logic [MW-1:0]     POS_LIM = MW'((1 << (QWIDTH - 1)) - 1);
  localparam logic [MW-1:0]     NEG_LIM = MW'(1 << (QWIDTH - 1));
  localparam logic [QWIDTH-1:0] QPOS    = {1'b0, {(QWIDTH-1){1'b1}}};
  localparam logic [QWIDTH-1:0] QNEG    = {1'b1, {(QWIDTH-1){1'b0}}};

  // Returns {sat, q} for one FP32 word at the given step exponent.
  function automatic logic [QWIDTH:0] quant_lane(input logic [31:0] w,
                                                 input logic signed [EXPLENGTH-1:0] step);
    logic                  s;
    logic [7:0]            e;
    logic [23:0]           sig;
    logic signed [SHW-1:0] sh;
    logic [MW-1:0]         mag;
    logic [MW-1:0]         negm;
    logic                  big;
    logic                  sat;
    logic [QWIDTH-1:0]     q;
    s    = w[31];
    e    = w[30:23];
    sig  = {1'b1, w[22:0]};
    sh   = $signed(SHW'(e)) - $signed(SHW'(127)) - SHW'(step);
    mag  = '0;
    big  = 1'b0;
    sat  = 1'b0;
    q    = '0;
    negm = '0;
    // Any shift beyond the mantissa width already exceeds every supported QWIDTH.
    if (sh > 23) begin
      big = 1'b1;
    end else if (sh >= 0) begin
      mag = MW'(sig >> (5'd23 - 5'(sh)));
`ifdef QUANT_ROUND_NEAREST_EN
      if (sh < 23) mag = mag + MW'(sig[5'd22 - 5'(sh)]);
`endif
    end
`ifdef QUANT_ROUND_NEAREST_EN
    else if (sh == -1) begin
      mag = MW'(1);
    end
`endif
    if (e == 8'd0) begin
      q   = '0;
      sat = 1'b0;
    end else if (e == 8'hFF) begin
      q   = s ? QNEG : QPOS;
      sat = 1'b1;
    end else if (s) begin
      if (big || (mag > NEG_LIM)) begin
        q   = QNEG;
        sat = 1'b1;
      end else begin
        negm = -mag;
        q    = negm[QWIDTH-1:0];
      end
    end else begin
      if (big || (mag > POS_LIM)) begin
        q   = QPOS;
        sat = 1'b1;
      end else begin
        q = mag[QWIDTH-1:0];
      end
    end
    return {sat, q};
  endfunction

  logic [1:0]                  state;
  logic [CW-1:0]               cnt;
  logic [L2WIDTH-1:0]          line_p0;
  logic signed [EXPLENGTH-1:0] step_p0;
  logic [WWIDTH-1:0]           word_p0;
  logic [QWIDTH:0]             lane_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign word_p0   = line_p0[cnt*WWIDTH +: WWIDTH];
  assign lane_res  = quant_lane(word_p0, step_p0);

  // Stage p0: captured line and step, held while lanes are converted.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && in_valid) begin
      line_p0 <= in_line;
      step_p0 <= StepSizeExp;
    end
  end

  // Lane conversion writes straight into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      out_line <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state   <= CONVERT;
            cnt     <= '0;
            out_sat <= 1'b0;
          end
        end
        CONVERT: begin
          out_line[cnt*QWIDTH +: QWIDTH] <= lane_res[QWIDTH-1:0];
          out_sat <= out_sat | lane_res[QWIDTH];
          if (cnt == CW'(LANES - 1)) state <= HOLD;
          else cnt <= cnt + 1'b1;
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
